// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit_if
// Description : Control-unit to PC/return-stack bundle. The master drives
//               the per-instruction update request, the slave returns the
//               fetch address and return-stack status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_stack_unit_if #(
    parameter int PC_W = 32
);
    logic            pc_update;
    logic [1:0]      PC_src;
    logic            is_call;
    logic            is_ret;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_offset;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] ra_top;
    logic            stack_empty;
    logic            stack_full;
    logic            stack_err;

    modport master (
        output pc_update, PC_src, is_call, is_ret, jump_target, branch_offset,
        input  pc, pc_plus1, ra_top, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  pc_update, PC_src, is_call, is_ret, jump_target, branch_offset,
        output pc, pc_plus1, ra_top, stack_empty, stack_full, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : Program-counter register with an integrated hardware
//               return-address LIFO. CALL pushes pc+1, RET pops it back.
//               Overflow/underflow set a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire              clk,
    input  wire              reset,
    pc_stack_unit_if.slave   bus
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_CW = c_IW + 1;

    logic [PC_W-1:0] r_pc;
    logic [c_CW-1:0] r_count;
    logic            r_err;
    logic [PC_W-1:0] r_stack [DEPTH];

    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_ra_top;
    logic [PC_W-1:0] w_next_pc;
    logic [c_IW-1:0] w_top_idx;
    logic [c_IW-1:0] w_push_idx;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_set_err;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CW'(DEPTH));
    assign w_top_idx  = c_IW'(r_count - c_CW'(1));
    // A push only happens when not full, so count fits the index width.
    assign w_push_idx = c_IW'(r_count);
    assign w_ra_top   = w_empty ? '0 : r_stack[w_top_idx];

    // Next-PC selection and stack push/pop/error decisions.
    always_comb begin
        w_next_pc = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_err = 1'b0;
        if (bus.pc_update) begin
            case (bus.PC_src)
                2'b00: w_next_pc = w_pc_plus1;
                2'b10: w_next_pc = r_pc + bus.branch_offset;
                2'b01: begin
                    if (bus.is_call) begin
                        // The jump is taken even when the push is dropped.
                        w_next_pc = bus.jump_target;
                        if (w_full) w_set_err = 1'b1;
                        else        w_push    = 1'b1;
                    end else if (bus.is_ret) begin
                        if (w_empty) begin
                            w_next_pc = w_pc_plus1;
                            w_set_err = 1'b1;
                        end else begin
                            w_next_pc = w_ra_top;
                            w_pop     = 1'b1;
                        end
                    end else begin
                        w_next_pc = bus.jump_target;
                    end
                end
                default: w_next_pc = r_pc;
            endcase
        end
    end

    // PC, stack depth and sticky error register; reset wins over any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_push)     r_count <= r_count + c_CW'(1);
            else if (w_pop) r_count <= r_count - c_CW'(1);
            if (w_set_err)  r_err   <= 1'b1;
        end
    end

    // Return-address storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_stack[w_push_idx] <= w_pc_plus1;
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus1    = w_pc_plus1;
    assign bus.ra_top      = w_ra_top;
    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.stack_err   = r_err;

endmodule
`default_nettype wire

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter register with an integrated return-address stack for the multi-cycle processor. It sits directly downstream of the control unit, consuming its `PC_src` selection and the per-instruction call/return qualifiers. It produces the fetch address for the IF stage. It also holds CALL return addresses in a hardware LIFO so that RET restores them without a memory access.

## Interface
Parameters:
- `PC_W`, default 32: PC and address width in bits.
- `DEPTH`, default 8: return-stack entries. Must be a power of 2 and at least 2.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`, in, 1: the single clock. All state updates occur on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `pc_update`, in, 1: high for exactly the cycle in which the current instruction completes, i.e. the control unit's next state is IF.
- `PC_src`, in, 2: next-PC select. 00 = sequential, 01 = jump/call/return, 10 = branch taken, 11 = reserved.
- `is_call`, in, 1: the current instruction is CALL.
- `is_ret`, in, 1: the current instruction is RET.
- `jump_target`, in, PC_W: absolute target for JMP and CALL.
- `branch_offset`, in, PC_W: sign-extended two's-complement branch displacement.
- `pc`, out, PC_W: current fetch address. Registered.
- `pc_plus1`, out, PC_W: `pc + 1`. Combinational.
- `ra_top`, out, PC_W: return address currently on top of the stack. Equals 0 when the stack is empty.
- `stack_empty`, out, 1: no entries on the stack.
- `stack_full`, out, 1: DEPTH entries on the stack.
- `stack_err`, out, 1: sticky flag set on overflow or underflow. Cleared only by reset.

## Operation
- Reset, on any edge with `reset`=1 (takes priority over all other inputs):
  - `pc` = RESET_PC.
  - Stack count = 0, so `stack_empty`=1 and `stack_full`=0.
  - `stack_err`=0 and `ra_top`=0.
  - Stack storage contents are don't-care.
- When `pc_update`=0, `pc`, the stack and `stack_err` all hold.
- When `pc_update`=1, the next PC is selected by `PC_src`:
  - **00**: `pc + 1`.
  - **10**: `pc + branch_offset`.
  - **11**: `pc` holds (reserved code, no side effects).
  - **01 with `is_call`=1**: push `pc + 1`, then `pc` = `jump_target`.
  - **01 with `is_ret`=1 and `is_call`=0**: pop, then `pc` = the popped value.
  - **01 with neither qualifier**: plain JMP, `pc` = `jump_target`. The stack is untouched.
- `is_call` and `is_ret` are ignored when `PC_src` ≠ 01.
- If both are high with `PC_src`=01, CALL wins and RET is ignored.
- Arithmetic is modulo 2^PC_W. Wrap-around is silent and is not an error.
- Overflow: a CALL while `stack_full`=1 suppresses the push (count stays at DEPTH, contents unchanged). The jump is still taken and `stack_err` is set.
- Underflow: a RET while `stack_empty`=1 makes `pc` = `pc + 1`. The count stays at 0 and `stack_err` is set.
- Stack organisation:
  - Count register spans 0..DEPTH, so it is clog2(DEPTH)+1 bits wide.
  - A push writes entry[count], then count is incremented.
  - A pop reads entry[count-1], then count is decremented.
  - `ra_top` = entry[count-1] when count>0, otherwise 0.

## Timing
- Single-cycle update: the new `pc`, count and `stack_err` are visible in the cycle after the `pc_update` edge.
- `pc_plus1`, `ra_top`, `stack_empty` and `stack_full` are derived from registered state and change only at clock edges.
- No handshake exists. The control unit guarantees `pc_update` is a one-cycle pulse per instruction. Back-to-back pulses on consecutive cycles must each be honoured.
- Reset asserted mid-instruction, including in the same cycle as `pc_update`, discards that update completely.
- There is no combinational path from any input to any output other than none. All outputs are functions of state only.

## Test plan
- Reset, then five `pc_update` pulses with `PC_src`=00 -> `pc` steps 0,1,2,3,4,5. With RESET_PC=0x40, the first `pc` after reset is 0x40.
- Branch with `pc`=0x10 and `branch_offset`=0xFFFFFFFC (-4), `PC_src`=10 -> `pc`=0x0C. With `pc`=0xFFFFFFFF and `PC_src`=00 -> `pc`=0, `stack_err` stays 0.
- Nested calls: at `pc`=0x20 CALL to 0x100, then at `pc`=0x100 CALL to 0x200 -> `ra_top`=0x101 with count 2. The first RET gives `pc`=0x101 and the second RET gives `pc`=0x21, with `stack_empty`=1 again.
- Overflow: 8 CALLs -> `stack_full`=1. A 9th CALL to 0x300 -> `pc`=0x300, `stack_err`=1 and `ra_top` unchanged. Then 8 RETs return the original addresses in LIFO order.
- Underflow: after reset, RET at `pc`=0x5 -> `pc`=0x6, `stack_err`=1 and `stack_empty`=1. A JMP with neither qualifier to 0x80 -> `pc`=0x80 and the stack is unchanged.
- Reset mid-operation: with two entries pushed, assert `reset` together with `pc_update` and a CALL -> next cycle `pc`=RESET_PC, `stack_empty`=1, `stack_err`=0. Holding `pc_update`=0 for 3 cycles -> `pc` stable.
